ram_sram_sequencer: RTL and testbench
=====================================

Name: ram_sram_sequencer

Overview:
- Memory-clock-domain consumer of the SysClk→MemClk command FIFO.
- Pops one {data, address, cmd} entry at a time and runs the corresponding asynchronous SRAM write or read cycle on the external 512K×8 SRAM.
- Read data is pushed into the MemClk→SysClk return FIFO.
- One command is in flight at a time; it never issues a pop it cannot complete.

Parameters:
- pRamDqWidth, 8, SRAM data width.
- pRamAdrsWidth, 19, SRAM address width.
- pWrWaitCycle, 2, iMemClk cycles WE_n is held low (≥1).
- pRdWaitCycle, 2, iMemClk cycles from OE_n low to data sample (≥1).

Ports:
- iMemClk in 1: sole clock.
- iRst in 1: reset, asynchronous, active-high.
- iCmdWd in pRamDqWidth: write data from command FIFO.
- iCmdAdrs in pRamAdrsWidth: address from command FIFO.
- iCmd in 1: 1 = write, 0 = read.
- iCmdEmp in 1: command FIFO empty.
- iCmdRVd in 1: command FIFO read data valid.
- oCmdREd out 1: command FIFO pop strobe.
- iRetFull in 1: return FIFO full.
- oRetWd out pRamDqWidth: read data to return FIFO.
- oRetWEd out 1: return FIFO push strobe.
- oSramAdrs out pRamAdrsWidth: SRAM address.
- oSramDq out pRamDqWidth: SRAM write data.
- oSramDqOe out 1: DQ output enable for the top-level tristate.
- iSramDq in pRamDqWidth: SRAM DQ input.
- oSramCe_n, oSramWe_n, oSramOe_n out 1 each: SRAM strobes, active-low.
- oBusy out 1: high in every state except IDLE.

Behaviour:
- Clocking and reset:
  - One clock (iMemClk); reset iRst is asynchronous and active-high.
  - All outputs are registered.
  - Reset values: oCmdREd=0, oRetWEd=0, oRetWd=0, oSramAdrs=0, oSramDq=0, oSramDqOe=0, oSramCe_n=1, oSramWe_n=1, oSramOe_n=1, oBusy=0, state=IDLE, wait counter=0.
  - Reset asserted mid-operation aborts immediately: strobes go inactive and DQ is released in the same instant. The popped command is lost, which is acceptable because both FIFOs share iRst.
- FSM states: IDLE, FETCH, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, RD_PUSH.
- IDLE:
  - If !iCmdEmp && !iRetFull: oCmdREd=1 for exactly one cycle, then go to FETCH.
  - The iRetFull gate applies to writes too, which keeps the rule simple.
  - iCmdRVd is ignored in IDLE.
- FETCH:
  - Wait indefinitely for iCmdRVd.
  - On iCmdRVd, latch iCmdWd, iCmdAdrs and iCmd.
  - iCmd=1 goes to WR_SETUP; iCmd=0 goes to RD_ACCESS.
- WR_SETUP (1 cycle): oSramAdrs=adrs, oSramDq=wd, oSramDqOe=1, Ce_n=0, We_n=1, Oe_n=1.
- WR_PULSE (pWrWaitCycle cycles): We_n=0; address and data held.
- WR_HOLD (1 cycle): We_n=1, address and data held. Next cycle: DqOe=0, Ce_n=1, go to IDLE.
- RD_ACCESS (pRdWaitCycle cycles):
  - oSramAdrs=adrs, DqOe=0, Ce_n=0, Oe_n=0.
  - iSramDq is captured on the last cycle.
- RD_PUSH (1 cycle): oRetWd=captured data, oRetWEd=1, Oe_n=1, Ce_n=1, then go to IDLE.
- Latency, with the pop in cycle 0 and RVd seen in cycle k:
  - Write: We_n low from k+2 through k+1+pWrWaitCycle; back in IDLE at k+3+pWrWaitCycle.
  - Read: oRetWEd asserted in cycle k+1+pRdWaitCycle.
- DQ contention rule:
  - oSramDqOe=1 only in WR_SETUP, WR_PULSE and WR_HOLD, with Oe_n=1 in all three.
  - Oe_n=0 never coincides with DqOe=1.
  - Read→write turnaround is guaranteed by WR_SETUP.
- Wait counter:
  - Width is clog2(max(pWrWaitCycle, pRdWaitCycle))+1.
  - Loads 0 on state entry and increments each cycle.
  - The exit condition is compare-equal to (param−1).
- oCmdREd and oRetWEd are single-cycle pulses and are never asserted back-to-back.
- Minimum command period: 4+pWrWaitCycle cycles (write) and 3+pRdWaitCycle cycles (read), plus FIFO read latency.

Decomposition:
- Shared package ram_pkg holds:
  - the FSM state encoding constants;
  - CMD_WRITE=1'b1 and CMD_READ=1'b0;
  - default widths 8/19.
- No sub-module; the wait counter stays inline.
- The DQ tristate buffer belongs at the top level, not in this block.

Test Plan:
- Write, pWrWaitCycle=2: FIFO holds {wd=8'hA5, adrs=19'h12345, cmd=1}, RVd one cycle after REd → oCmdREd pulses once; oSramAdrs=19'h12345, oSramDq=8'hA5; We_n low exactly 2 cycles with Ce_n=0, Oe_n=1, DqOe=1 throughout; returns to IDLE, oBusy=0.
- Read, pRdWaitCycle=2: {adrs=19'h7FFFF, cmd=0}, SRAM model drives 8'h3C → Oe_n low 2 cycles, DqOe=0; single oRetWEd pulse with oRetWd=8'h3C; no We_n activity.
- Back-to-back: write 8'h11 to adrs 5 followed by read of adrs 5 → read returns 8'h11; assertion shows DqOe=1 and Oe_n=0 never overlap.
- Backpressure: iRetFull=1 with command FIFO non-empty → oCmdREd stays 0 for 20 cycles; after iRetFull drops, pop occurs on the next cycle.
- Reset mid-operation: assert iRst during WR_PULSE → We_n=1, Ce_n=1, DqOe=0 immediately, without waiting for a clock edge; after release, with the FIFO empty, the block stays in IDLE with no strobes.
- Delayed RVd: RVd arrives 5 cycles after REd → FSM holds in FETCH with strobes inactive; the command then executes normally.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the MemClk-side SRAM sequencer: state encoding,
// command opcodes and default SRAM geometry (512K x 8).
package ram_pkg;

   localparam int DEF_DQ_WIDTH   = 8;
   localparam int DEF_ADRS_WIDTH = 19;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_WR_SETUP  = 3'd2,
      ST_WR_PULSE  = 3'd3,
      ST_WR_HOLD   = 3'd4,
      ST_RD_ACCESS = 3'd5,
      ST_RD_PUSH   = 3'd6
   } state_t;

endpackage

// File: rtl/ram_sram_sequencer.sv
// Pops one command at a time from the SysClk->MemClk FIFO and runs the
// matching asynchronous SRAM write or read cycle. Read data goes to the
// return FIFO. Every output is a register whose next value is derived from
// the next state, so strobes line up exactly with the state they belong to.
module ram_sram_sequencer
   import ram_pkg::*;
#(
   parameter int pRamDqWidth   = DEF_DQ_WIDTH,
   parameter int pRamAdrsWidth = DEF_ADRS_WIDTH,
   parameter int pWrWaitCycle  = 2,
   parameter int pRdWaitCycle  = 2
) (
   input  logic                     iMemClk,
   input  logic                     iRst,
   input  logic [pRamDqWidth-1:0]   iCmdWd,
   input  logic [pRamAdrsWidth-1:0] iCmdAdrs,
   input  logic                     iCmd,
   input  logic                     iCmdEmp,
   input  logic                     iCmdRVd,
   output logic                     oCmdREd,
   input  logic                     iRetFull,
   output logic [pRamDqWidth-1:0]   oRetWd,
   output logic                     oRetWEd,
   output logic [pRamAdrsWidth-1:0] oSramAdrs,
   output logic [pRamDqWidth-1:0]   oSramDq,
   output logic                     oSramDqOe,
   input  logic [pRamDqWidth-1:0]   iSramDq,
   output logic                     oSramCe_n,
   output logic                     oSramWe_n,
   output logic                     oSramOe_n,
   output logic                     oBusy
);

   localparam int MAX_WAIT = (pWrWaitCycle > pRdWaitCycle) ? pWrWaitCycle : pRdWaitCycle;
   localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(pWrWaitCycle - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(pRdWaitCycle - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t                     state, state_next;
   logic [CNT_W-1:0]           wait_cnt, wait_cnt_next;

   logic                       cmd_red_next;
   logic                       ret_wed_next;
   logic [pRamDqWidth-1:0]     ret_wd_next;
   logic [pRamAdrsWidth-1:0]   sram_adrs_next;
   logic [pRamDqWidth-1:0]     sram_dq_next;
   logic                       dq_oe_next;
   logic                       ce_n_next;
   logic                       we_n_next;
   logic                       oe_n_next;
   logic                       busy_next;

   // State register and wait counter; the counter restarts on every state change.
   always_ff @(posedge iMemClk or posedge iRst) begin
      if (iRst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Next-state logic: one command in flight, pop only when the result has room.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:      if (!iCmdEmp && !iRetFull) state_next = ST_FETCH;
         ST_FETCH:     if (iCmdRVd) state_next = (iCmd == CMD_WRITE) ? ST_WR_SETUP : ST_RD_ACCESS;
         ST_WR_SETUP:  state_next = ST_WR_PULSE;
         ST_WR_PULSE:  if (wait_cnt == WR_LAST) state_next = ST_WR_HOLD;
         ST_WR_HOLD:   state_next = ST_IDLE;
         ST_RD_ACCESS: if (wait_cnt == RD_LAST) state_next = ST_RD_PUSH;
         ST_RD_PUSH:   state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
      wait_cnt_next = (state_next != state) ? '0 : wait_cnt + CNT_ONE;
   end

   // Output values for the coming cycle, decoded from the state being entered.
   always_comb begin
      cmd_red_next   = (state == ST_IDLE) && (state_next == ST_FETCH);
      ret_wed_next   = (state_next == ST_RD_PUSH);
      ret_wd_next    = oRetWd;
      sram_adrs_next = oSramAdrs;
      sram_dq_next   = oSramDq;
      // Latch the fetched command straight into the SRAM-facing registers.
      if (state == ST_FETCH && iCmdRVd) begin
         sram_adrs_next = iCmdAdrs;
         sram_dq_next   = iCmdWd;
      end
      // Sample DQ at the end of the last access cycle.
      if (state == ST_RD_ACCESS && wait_cnt == RD_LAST) begin
         ret_wd_next = iSramDq;
      end
      dq_oe_next = (state_next == ST_WR_SETUP) || (state_next == ST_WR_PULSE) ||
                   (state_next == ST_WR_HOLD);
      ce_n_next  = !(dq_oe_next || (state_next == ST_RD_ACCESS));
      we_n_next  = (state_next != ST_WR_PULSE);
      oe_n_next  = (state_next != ST_RD_ACCESS);
      busy_next  = (state_next != ST_IDLE);
   end

   // Output registers; reset drops every strobe and releases DQ at once.
   always_ff @(posedge iMemClk or posedge iRst) begin
      if (iRst) begin
         oCmdREd   <= 1'b0;
         oRetWEd   <= 1'b0;
         oRetWd    <= '0;
         oSramAdrs <= '0;
         oSramDq   <= '0;
         oSramDqOe <= 1'b0;
         oSramCe_n <= 1'b1;
         oSramWe_n <= 1'b1;
         oSramOe_n <= 1'b1;
         oBusy     <= 1'b0;
      end else begin
         oCmdREd   <= cmd_red_next;
         oRetWEd   <= ret_wed_next;
         oRetWd    <= ret_wd_next;
         oSramAdrs <= sram_adrs_next;
         oSramDq   <= sram_dq_next;
         oSramDqOe <= dq_oe_next;
         oSramCe_n <= ce_n_next;
         oSramWe_n <= we_n_next;
         oSramOe_n <= oe_n_next;
         oBusy     <= busy_next;
      end
   end

endmodule

// File: tb/tb_ram_sram_sequencer.sv
// Self-checking bench for ram_sram_sequencer: directed table vectors,
// randomized commands against an order-based memory reference model, and
// hand-written reset / backpressure sequences.
module tb_ram_sram_sequencer;
   import ram_pkg::*;

   localparam int DW   = 8;
   localparam int AW   = 19;
   localparam int WR_W = 2;
   localparam int RD_W = 2;

   logic          iMemClk = 1'b0;
   logic          iRst;
   logic [DW-1:0] iCmdWd;
   logic [AW-1:0] iCmdAdrs;
   logic          iCmd;
   logic          iCmdEmp;
   logic          iCmdRVd;
   logic          oCmdREd;
   logic          iRetFull;
   logic [DW-1:0] oRetWd;
   logic          oRetWEd;
   logic [AW-1:0] oSramAdrs;
   logic [DW-1:0] oSramDq;
   logic          oSramDqOe;
   logic [DW-1:0] iSramDq;
   logic          oSramCe_n;
   logic          oSramWe_n;
   logic          oSramOe_n;
   logic          oBusy;

   int checks = 0;
   int errors = 0;

   ram_sram_sequencer #(
      .pRamDqWidth(DW), .pRamAdrsWidth(AW),
      .pWrWaitCycle(WR_W), .pRdWaitCycle(RD_W)
   ) dut (
      .iMemClk(iMemClk), .iRst(iRst),
      .iCmdWd(iCmdWd), .iCmdAdrs(iCmdAdrs), .iCmd(iCmd),
      .iCmdEmp(iCmdEmp), .iCmdRVd(iCmdRVd), .oCmdREd(oCmdREd),
      .iRetFull(iRetFull), .oRetWd(oRetWd), .oRetWEd(oRetWEd),
      .oSramAdrs(oSramAdrs), .oSramDq(oSramDq), .oSramDqOe(oSramDqOe),
      .iSramDq(iSramDq), .oSramCe_n(oSramCe_n), .oSramWe_n(oSramWe_n),
      .oSramOe_n(oSramOe_n), .oBusy(oBusy)
   );

   always #5 iMemClk = ~iMemClk;

   // Power-up content of the SRAM model (and of the reference for untouched cells).
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // SRAM model: drives DQ only while selected and output-enabled.
   logic [DW-1:0] sram [0:(1<<AW)-1];
   assign iSramDq = (!oSramCe_n && !oSramOe_n) ? sram[oSramAdrs] : 8'hEE;
   always @(posedge iMemClk)
      if (!iRst && !oSramCe_n && !oSramWe_n) sram[oSramAdrs] <= oSramDq;

   // Reference model: last value written to each address, in command order.
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Bus rules checked every cycle outside reset.
   logic prev_red = 1'b0, prev_wed = 1'b0;
   always @(negedge iMemClk) begin
      if (iRst) begin
         prev_red = 1'b0;
         prev_wed = 1'b0;
      end else begin
         checks++;
         if ((oSramDqOe && !oSramOe_n) || (!oSramWe_n && (oSramCe_n || !oSramDqOe)) ||
             (!oSramOe_n && oSramCe_n) || (oCmdREd && prev_red) || (oRetWEd && prev_wed)) begin
            errors++;
            $display("FAIL bus_rule @%0t: dqoe=%b oe_n=%b we_n=%b ce_n=%b red=%b/%b wed=%b/%b",
                     $time, oSramDqOe, oSramOe_n, oSramWe_n, oSramCe_n,
                     prev_red, oCmdREd, prev_wed, oRetWEd);
         end
         prev_red = oCmdREd;
         prev_wed = oRetWEd;
      end
   end

   typedef struct {
      bit            cmd;
      logic [AW-1:0] adrs;
      logic [DW-1:0] wd;
      int            dly;     // cycles from pop to RVd (>=1)
      int            full;    // cycles iRetFull is held high before release
      logic [DW-1:0] exp_rd;
   } vec_t;

   task automatic drive_junk();
      iCmdWd   = DW'($urandom);
      iCmdAdrs = AW'($urandom);
      iCmd     = 1'($urandom);
   endtask

   // Runs one command through the DUT; samples on falling edges, cycle 0 = pop.
   task automatic run_cmd(input int id, input vec_t v);
      int n = 0, cyc = 0, pop_idx = -1, red_cnt = 0;
      int we_first = -1, we_cnt = 0, oe_first = -1, oe_cnt = 0;
      int ret_cyc = -1, ret_cnt = 0, idle_cyc = -1, dqoe_cnt = 0, ce_cnt = 0;
      int hold_bad = 0, fetch_bad = 0;
      bit popped = 0, timed_out = 0;
      logic [DW-1:0] ret_data = '0;
      logic [3:0] idle_strb = '0;
      iCmdEmp  = 1'b0;
      iRetFull = (v.full > 0);
      iCmdRVd  = 1'b0;
      drive_junk();
      while (1) begin
         @(negedge iMemClk);
         n++;
         if (n > 200) begin timed_out = 1; break; end
         if (!popped) begin
            if (oCmdREd) begin
               popped = 1; pop_idx = n; cyc = 0; red_cnt = 1; iCmdEmp = 1'b1;
            end else if (n == v.full) begin
               iRetFull = 1'b0;
            end
         end else begin
            cyc++;
            if (oCmdREd) red_cnt++;
            if (oSramDqOe) dqoe_cnt++;
            if (!oSramCe_n) ce_cnt++;
            if (!oSramWe_n) begin
               if (we_cnt == 0) we_first = cyc;
               we_cnt++;
               if (oSramAdrs !== v.adrs || oSramDq !== v.wd || !oSramOe_n) hold_bad++;
            end
            if (!oSramOe_n) begin
               if (oe_cnt == 0) oe_first = cyc;
               oe_cnt++;
               if (oSramAdrs !== v.adrs) hold_bad++;
            end
            if (oRetWEd) begin ret_cnt++; ret_cyc = cyc; ret_data = oRetWd; end
            if (cyc <= v.dly && (!oSramCe_n || !oSramWe_n || !oSramOe_n || oSramDqOe || !oBusy))
               fetch_bad++;
            if (!oBusy) begin
               idle_cyc  = cyc;
               idle_strb = {oSramCe_n, oSramWe_n, oSramOe_n, oSramDqOe};
               break;
            end
         end
         if (popped && cyc == v.dly) begin
            iCmdRVd = 1'b1; iCmd = v.cmd; iCmdAdrs = v.adrs; iCmdWd = v.wd;
         end else begin
            iCmdRVd = 1'b0;
            drive_junk();
         end
      end
      iCmdRVd  = 1'b0;
      iCmdEmp  = 1'b1;
      iRetFull = 1'b0;
      if (timed_out) begin
         chk("timeout", 32'd1, 32'd0);
         return;
      end
      chk("pop_latency", pop_idx, v.full + 1);
      chk("pop_count", red_cnt, 1);
      chk("fetch_quiet", fetch_bad, 0);
      chk("addr_data_hold", hold_bad, 0);
      chk("idle_strobes", idle_strb, 4'b1110);
      if (v.cmd == CMD_WRITE) begin
         chk("we_first", we_first, v.dly + 2);
         chk("we_len", we_cnt, WR_W);
         chk("wr_dqoe_len", dqoe_cnt, WR_W + 2);
         chk("wr_ce_len", ce_cnt, WR_W + 2);
         chk("wr_no_oe", oe_cnt, 0);
         chk("wr_no_ret", ret_cnt, 0);
         chk("wr_idle", idle_cyc, v.dly + 3 + WR_W);
         ref_mem[v.adrs] = v.wd;
      end else begin
         chk("oe_first", oe_first, v.dly + 1);
         chk("oe_len", oe_cnt, RD_W);
         chk("rd_ce_len", ce_cnt, RD_W);
         chk("rd_no_we", we_cnt, 0);
         chk("rd_no_dqoe", dqoe_cnt, 0);
         chk("ret_count", ret_cnt, 1);
         chk("ret_cycle", ret_cyc, v.dly + 1 + RD_W);
         chk("ret_data", ret_data, v.exp_rd);
         chk("rd_idle", idle_cyc, v.dly + 2 + RD_W);
      end
      $display("txn %0d %s adrs=%05h wd=%02h dly=%0d full=%0d ret=%02h exp=%02h",
               id, v.cmd ? "WR" : "RD", v.adrs, v.wd, v.dly, v.full, ret_data, v.exp_rd);
   endtask

   vec_t          tbl [7];
   logic [AW-1:0] pool [6];

   initial begin
      vec_t v;
      int   n;
      bit   got;
      int   quiet_bad;

      for (int i = 0; i < (1 << AW); i++) sram[i] = init_val(AW'(i));
      sram[19'h7FFFF]    = 8'h3C;
      ref_mem[19'h7FFFF] = 8'h3C;

      tbl[0] = '{1'b1, 19'h12345, 8'hA5, 1, 0,  8'h00};
      tbl[1] = '{1'b0, 19'h7FFFF, 8'h00, 1, 0,  8'h3C};
      tbl[2] = '{1'b1, 19'h00005, 8'h11, 1, 0,  8'h00};
      tbl[3] = '{1'b0, 19'h00005, 8'h00, 1, 0,  8'h11};
      tbl[4] = '{1'b0, 19'h12345, 8'h00, 1, 20, 8'hA5};
      tbl[5] = '{1'b1, 19'h00777, 8'h5E, 5, 0,  8'h00};
      tbl[6] = '{1'b0, 19'h00777, 8'h00, 5, 0,  8'h5E};

      iRst = 1'b1; iCmdEmp = 1'b1; iRetFull = 1'b0; iCmdRVd = 1'b0;
      iCmdWd = '0; iCmdAdrs = '0; iCmd = 1'b0;
      repeat (2) @(negedge iMemClk);
      chk("reset_ctrl", {oCmdREd, oRetWEd, oSramDqOe, oSramCe_n, oSramWe_n, oSramOe_n, oBusy},
          7'b0001110);
      chk("reset_data", {oRetWd, oSramDq, oSramAdrs}, '0);
      iRst = 1'b0;
      repeat (3) @(negedge iMemClk);
      chk("idle_empty", {oBusy, oCmdREd}, 2'b00);

      for (int i = 0; i < 7; i++) run_cmd(i, tbl[i]);

      for (int i = 0; i < 6; i++) pool[i] = {3'b101, 16'($urandom)};
      for (int i = 0; i < 40; i++) begin
         v.cmd  = 1'($urandom_range(0, 1));
         v.adrs = pool[$urandom_range(0, 5)];
         v.wd   = DW'($urandom);
         v.dly  = $urandom_range(1, 4);
         v.full = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         v.exp_rd = ref_read(v.adrs);
         run_cmd(100 + i, v);
      end

      // Reset in the middle of a write pulse.
      iCmdEmp = 1'b0; n = 0; got = 0;
      while (!got && n < 10) begin @(negedge iMemClk); n++; got = oCmdREd; end
      chk("rst_pop", got, 1);
      iCmdEmp = 1'b1;
      @(negedge iMemClk);
      iCmdRVd = 1'b1; iCmd = CMD_WRITE; iCmdAdrs = 19'h00ABC; iCmdWd = 8'hC3;
      @(negedge iMemClk);
      iCmdRVd = 1'b0;
      n = 0; got = 0;
      while (!got && n < 10) begin @(negedge iMemClk); n++; got = !oSramWe_n; end
      chk("rst_we_seen", got, 1);
      #2 iRst = 1'b1;
      #1 chk("rst_async", {oSramWe_n, oSramCe_n, oSramOe_n, oSramDqOe, oBusy}, 5'b11100);
      repeat (2) @(negedge iMemClk);
      iRst = 1'b0;
      quiet_bad = 0;
      repeat (10) begin
         @(negedge iMemClk);
         if (oCmdREd || oBusy || !oSramCe_n || !oSramWe_n || !oSramOe_n || oSramDqOe || oRetWEd)
            quiet_bad++;
      end
      chk("post_reset_quiet", quiet_bad, 0);
      $display("txn reset_mid_write done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
